axil_write_master: RTL
======================

// Module: axil_write_master
// PURPOSE
//  Write-channel engine for the insertion-sort datapath. Sits directly downstream of the sort controller.
//  On a start pulse it latches one address/data pair and runs a full AW/W/B write transaction to memory.
//  It then returns a done pulse and a held write response, used for the controller's shift-left/shift-right writes.
// PARAMETERS
//  ADDR_WDTH       4    width of write_addr / aw_addr
//  DATA_WDTH       32   width of write_data / w_data
//  RESP_WDTH       1    width of b_resp / b_resp_out; nonzero = success, zero = failure
//  TIMEOUT_CYCLES  255  max cycles spent in S_WAIT_B before forced failure; legal range 1..2^TMO_WDTH-1
//  TMO_WDTH        8    width of the timeout counter
// PORTS
//  clk         in   1          clock, rising edge
//  rst_n       in   1          asynchronous, active-low reset
//  start       in   1          request a write; accepted only in S_IDLE or S_RESP
//  write_addr  in   ADDR_WDTH  address, sampled on an accepted start
//  write_data  in   DATA_WDTH  data, sampled on an accepted start
//  done        out  1          one-cycle pulse: transaction finished
//  b_resp_out  out  RESP_WDTH  response of the last finished transaction (held)
//  busy        out  1          high in any state other than S_IDLE
//  timeout     out  1          sticky: last transaction ended by timeout
//  aw_valid    out  1          AW valid
//  aw_ready    in   1          AW ready
//  aw_addr     out  ADDR_WDTH  AW address (latched copy)
//  w_valid     out  1          W valid
//  w_ready     in   1          W ready
//  w_data      out  DATA_WDTH  W data (latched copy)
//  b_valid     in   1          B valid
//  b_ready     out  1          B ready
//  b_resp      in   RESP_WDTH  B response
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=S_IDLE
//   - all outputs 0, including aw_addr, w_data and b_resp_out
//   - timeout counter 0
//   - an in-flight transaction is abandoned; no done pulse follows.
//  States and outputs:
//   - S_IDLE:   no valids asserted
//   - S_AW_W:   aw_valid=1, w_valid=1
//   - S_AW:     aw_valid=1 only; W already accepted
//   - S_W:      w_valid=1 only; AW already accepted
//   - S_WAIT_B: b_ready=1
//   - S_RESP:   done=1
//  Start, accepted in S_IDLE or S_RESP:
//   - latch write_addr->aw_addr and write_data->w_data
//   - clear timeout; go to S_AW_W
//   - start in any other state is ignored; latched values are unchanged.
//  S_AW_W transitions:
//   - aw_ready & w_ready -> S_WAIT_B
//   - aw_ready only -> S_W
//   - w_ready only -> S_AW
//   - neither -> stay.
//  S_AW: aw_ready -> S_WAIT_B.
//  S_W: w_ready -> S_WAIT_B.
//  Valid rule: a valid, once raised, stays high until its own handshake; aw_addr/w_data are stable meanwhile.
//  S_WAIT_B:
//   - counter increments each cycle; it is cleared on entry
//   - b_valid -> b_resp_out<=b_resp, go to S_RESP
//   - b_valid wins if it coincides with expiry
//   - counter reaches TIMEOUT_CYCLES without b_valid -> b_resp_out<=0, timeout<=1, go to S_RESP.
//  S_RESP:
//   - lasts exactly one cycle; goes to S_IDLE, or to S_AW_W if start is high that cycle.
//  b_resp_out and timeout change only on S_WAIT_B exit or reset (timeout also clears on accepted start).
//   - both are held through S_IDLE and the next transaction, so the controller may sample them after done.
//  Latency: start at cycle 0 -> valids high at cycle 1.
//   - with ready/b_valid immediate, S_WAIT_B at cycle 2, done at cycle 3; 3 cycles is the minimum.
//  Handshake inputs are ignored in states that do not use them (e.g. b_valid outside S_WAIT_B, stray aw_ready in S_W).
//  All outputs are registered or decoded from state only; no combinational input->output path.
// TESTING
//  - Reset with start=1, all readies 1 -> all outputs 0; after release with start=0, busy stays 0.
//  - start, addr=4'h3, data=32'hDEADBEEF; aw_ready=w_ready=b_valid=1, b_resp=1:
//    - aw_valid/w_valid high at cycle 1 with aw_addr=3, w_data=DEADBEEF
//    - done at cycle 3 only; b_resp_out=1 from cycle 3 onwards.
//  - w_ready at cycle 1, aw_ready delayed to cycle 5:
//    - w_valid drops at cycle 2; aw_valid is held through cycle 5
//    - S_WAIT_B at cycle 6; done one cycle after b_valid.
//  - AW/W complete, b_valid never rises, TIMEOUT_CYCLES=4:
//    - done 4 cycles after S_WAIT_B entry
//    - b_resp_out=0, timeout=1; both held until the next accepted start.
//  - start during S_AW_W with new addr/data -> ignored, aw_addr/w_data unchanged; start in S_RESP cycle -> back-to-back.
//  - b_resp=0 on B -> b_resp_out=0 at done, timeout=0; rst_n low mid-S_W -> immediate S_IDLE, no done pulse.

Source files
------------

// File: rtl/axil_write_master.sv
// AXI-Lite write-channel engine: latches one addr/data pair per start and runs
// an AW/W/B transaction, reporting done plus a held response and timeout flag.
module axil_write_master #(
    parameter int ADDR_WDTH      = 4,
    parameter int DATA_WDTH      = 32,
    parameter int RESP_WDTH      = 1,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_WDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_WDTH-1:0] write_addr,
    input  logic [DATA_WDTH-1:0] write_data,
    output logic                 done,
    output logic [RESP_WDTH-1:0] b_resp_out,
    output logic                 busy,
    output logic                 timeout,
    output logic                 aw_valid,
    input  logic                 aw_ready,
    output logic [ADDR_WDTH-1:0] aw_addr,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [DATA_WDTH-1:0] w_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [RESP_WDTH-1:0] b_resp
);

    // state    | meaning
    // S_IDLE   | waiting for start
    // S_AW_W   | AW and W both pending
    // S_AW     | W accepted, AW pending
    // S_W      | AW accepted, W pending
    // S_WAIT_B | both accepted, waiting for B or timeout
    // S_RESP   | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AW_W   = 3'd1,
        S_AW     = 3'd2,
        S_W      = 3'd3,
        S_WAIT_B = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    localparam logic [TMO_WDTH-1:0] TMO_LAST = TMO_WDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_WDTH-1:0] TMO_ONE  = TMO_WDTH'(1);

    state_t              state;
    state_t              state_nxt;
    logic [TMO_WDTH-1:0] tmo_cnt;
    logic                accept;
    logic                expire;

    assign accept = start && ((state == S_IDLE) || (state == S_RESP));
    // Counter holds the number of cycles already spent in S_WAIT_B.
    assign expire = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_AW_W;
            end
            S_AW_W: begin
                if (aw_ready && w_ready) state_nxt = S_WAIT_B;
                else if (aw_ready)       state_nxt = S_W;
                else if (w_ready)        state_nxt = S_AW;
            end
            S_AW: begin
                if (aw_ready) state_nxt = S_WAIT_B;
            end
            S_W: begin
                if (w_ready) state_nxt = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (b_valid || expire) state_nxt = S_RESP;
            end
            S_RESP: begin
                state_nxt = start ? S_AW_W : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        b_ready  = 1'b0;
        done     = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_AW_W: begin
                aw_valid = 1'b1;
                w_valid  = 1'b1;
            end
            S_AW:     aw_valid = 1'b1;
            S_W:      w_valid  = 1'b1;
            S_WAIT_B: b_ready  = 1'b1;
            S_RESP:   done     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == S_WAIT_B) begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
        end else begin
            tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_addr    <= '0;
            w_data     <= '0;
            b_resp_out <= '0;
            timeout    <= 1'b0;
        end else begin
            if (accept) begin
                aw_addr <= write_addr;
                w_data  <= write_data;
                timeout <= 1'b0;
            end
            // b_valid takes priority over a coincident expiry.
            if (state == S_WAIT_B) begin
                if (b_valid) begin
                    b_resp_out <= b_resp;
                end else if (expire) begin
                    b_resp_out <= '0;
                    timeout    <= 1'b1;
                end
            end
        end
    end

endmodule
